// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
//   Request/response front end for one single-port SRAM macro with a one-cycle
//   registered read. Each accepted request issues exactly one macro command in
//   the same cycle. Read data returns through a 2-entry FIFO in request order.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = write, 0 = read
//   req_addr, req_wdata       request address / write data
//   rsp_valid/rsp_ready       read-response handshake
//   rsp_rdata                 read data (FIFO head)
//   sram_CEB, sram_WEB        macro chip/write enables, active-low
//   sram_A, sram_D            macro address / write data
//   sram_Q                    macro read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_port_ctrl #(
    parameter int Bits       = 32,
    parameter int Word_Depth = 32,
    parameter int Add_Width  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [Add_Width-1:0] req_addr,
    input  logic [Bits-1:0]      req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [Bits-1:0]      rsp_rdata,
    output logic                 sram_CEB,
    output logic                 sram_WEB,
    output logic [Add_Width-1:0] sram_A,
    output logic [Bits-1:0]      sram_D,
    input  logic [Bits-1:0]      sram_Q
);

    if ((2 ** Add_Width) < Word_Depth) begin : g_bad_depth
        $error("sram_port_ctrl: Add_Width too small for Word_Depth");
    end

    localparam int Entries = 2;

    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic            inflight_q;
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [Bits-1:0] fifo_q [Entries];

    logic req_fire;
    logic rsp_fire;
    logic capture;
    logic read_room;
    logic [2:0] occupancy;

    // Reads only ever land in the FIFO via the in-flight flag, so the flag
    // gates the capture and sram_Q is ignored in every other cycle.
    assign capture = inflight_q;

    // Slots already claimed by reads that have not left yet. A response popped
    // this cycle frees a slot immediately, giving rsp_ready -> req_ready a
    // combinational path so sustained reads reach one per cycle.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign read_room = (occupancy - {2'b00, rsp_fire}) < 3'd2;

    assign req_ready = !RST && (req_write || read_room);
    assign req_fire  = req_valid && req_ready;

    // Gated with RST so stale FIFO contents are invisible during reset.
    assign rsp_valid = !RST && (count_q != 2'd0);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_q[rd_ptr_q];

    assign sram_CEB = !req_fire;
    assign sram_WEB = !(req_fire && req_write);
    assign sram_A   = req_addr;
    assign sram_D   = req_wdata;

    // capture with count = 2 cannot happen: read_room never admits a third read.
    assign count_d = count_q + {1'b0, capture} - {1'b0, rsp_fire};

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= req_fire && !req_write;
            if (capture) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (rsp_fire) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

    // Data storage carries no reset; validity is tracked by count_q alone.
    for (genvar gi = 0; gi < Entries; gi++) begin : g_fifo
        always_ff @(posedge CLK) begin
            if (!RST && capture && (wr_ptr_q == 1'(gi))) begin
                fifo_q[gi] <= sram_Q;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;

    localparam int Bits = 32;
    localparam int Depth = 32;
    localparam int Aw = 5;

    logic            CLK = 1'b0;
    logic            RST;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [Aw-1:0]   req_addr;
    logic [Bits-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [Bits-1:0] rsp_rdata;
    logic            sram_CEB;
    logic            sram_WEB;
    logic [Aw-1:0]   sram_A;
    logic [Bits-1:0] sram_D;
    logic [Bits-1:0] sram_Q;

    sram_port_ctrl #(.Bits(Bits), .Word_Depth(Depth), .Add_Width(Aw)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A),
        .sram_D(sram_D), .sram_Q(sram_Q)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Macro model: registered read; sram_Q is random junk whenever no read
    // was issued in the previous cycle.
    logic [Bits-1:0] mac_mem [Depth];
    logic [Bits-1:0] mac_q;
    assign sram_Q = mac_q;

    always @(posedge CLK) begin
        if (!sram_CEB && sram_WEB) begin
            mac_q <= mac_mem[sram_A];
        end else begin
            mac_q <= $urandom;
        end
        if (!sram_CEB && !sram_WEB) begin
            mac_mem[sram_A] = sram_D;
        end
    end

    // Reference model: memory image plus queue of accepted reads tagged
    // with their acceptance cycle.
    typedef struct {
        logic [Bits-1:0] data;
        int              cyc;
    } ent_t;

    logic [Bits-1:0] model_mem [Depth];
    ent_t            pend_q [$];
    int              cyc = 0;

    always @(negedge CLK) begin
        logic exp_rv;
        logic exp_rfire;
        logic exp_rr;
        logic exp_fire;
        if (RST) begin
            chk("rst_req_ready", req_ready, 1'b0);
            chk("rst_ceb", sram_CEB, 1'b1);
            chk("rst_web", sram_WEB, 1'b1);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            pend_q.delete();
        end else begin
            exp_rv = 1'b0;
            if (pend_q.size() > 0) begin
                exp_rv = (pend_q[0].cyc <= cyc - 2);
            end
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_rdata", rsp_rdata, pend_q[0].data);
            end
            exp_rfire = exp_rv && rsp_ready;
            exp_rr = req_write ? 1'b1 : ((pend_q.size() - int'(exp_rfire)) < 2);
            chk("req_ready", req_ready, exp_rr);
            exp_fire = req_valid && exp_rr;
            chk("sram_ceb", sram_CEB, !exp_fire);
            if (exp_fire) begin
                chk("sram_web", sram_WEB, !req_write);
                chk("sram_a", sram_A, req_addr);
                if (req_write) begin
                    chk("sram_d", sram_D, req_wdata);
                    model_mem[req_addr] = req_wdata;
                    $display("cyc %0d: WR addr=%0d data=%h", cyc, req_addr, req_wdata);
                end else begin
                    pend_q.push_back('{data: model_mem[req_addr], cyc: cyc});
                    $display("cyc %0d: RD addr=%0d", cyc, req_addr);
                end
            end else begin
                chk("sram_web_idle", sram_WEB, 1'b1);
            end
            if (exp_rfire) begin
                $display("cyc %0d: RSP data=%h", cyc, pend_q[0].data);
                void'(pend_q.pop_front());
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic [Bits-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = Aw'(a);
        req_wdata = d;
    endtask

    initial begin
        int acc;
        logic [Bits-1:0] exp10;
        logic [Bits-1:0] exp11;

        RST = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 0, '0);
        mac_q = '0;
        for (int i = 0; i < Depth; i++) begin
            logic [Bits-1:0] v;
            v = (i < 8) ? Bits'(i) : Bits'($urandom);
            mac_mem[i] = v;
            model_mem[i] = v;
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("first_cycle_ready", req_ready, 1'b1);
        step();

        // Back-to-back reads of preloaded addresses 0..7
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 1'b0, k, '0);
            else drive(1'b0, 1'b0, 0, '0);
            @(negedge CLK);
            if (k < 8) chk("b2b_ready", req_ready, 1'b1);
            if (k >= 2) begin
                chk("b2b_valid", rsp_valid, 1'b1);
                chk("b2b_data", rsp_rdata, 64'(k - 2));
            end
            step();
        end

        // Write then read back same address
        drive(1'b1, 1'b1, 3, 32'hDEADBEEF);
        @(negedge CLK);
        chk("wr_ceb", sram_CEB, 1'b0);
        chk("wr_web", sram_WEB, 1'b0);
        step();
        drive(1'b1, 1'b0, 3, '0);
        @(negedge CLK);
        chk("rd_ceb", sram_CEB, 1'b0);
        chk("rd_web", sram_WEB, 1'b1);
        step();
        drive(1'b0, 1'b0, 0, '0);
        @(negedge CLK);
        chk("raw_valid_n1", rsp_valid, 1'b0);
        step();
        @(negedge CLK);
        chk("raw_valid_n2", rsp_valid, 1'b1);
        chk("raw_data", rsp_rdata, 32'hDEADBEEF);
        step();

        // Back-pressure: four reads offered with rsp_ready low
        rsp_ready = 1'b0;
        exp10 = model_mem[10];
        exp11 = model_mem[11];
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 10 + k, '0);
            @(negedge CLK);
            if (req_ready) acc++;
            step();
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        drive(1'b1, 1'b1, 20, 32'h1234_5678);
        @(negedge CLK);
        chk("bp_write_ready", req_ready, 1'b1);
        step();
        drive(1'b1, 1'b0, 21, '0);
        @(negedge CLK);
        chk("bp_read_blocked", req_ready, 1'b0);
        step();
        drive(1'b0, 1'b0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("bp_hold", rsp_rdata, exp10);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("drain0", rsp_rdata, exp10);
        step();
        @(negedge CLK);
        chk("drain1", rsp_rdata, exp11);
        step();
        @(negedge CLK);
        chk("drain_empty", rsp_valid, 1'b0);
        step();

        // Reset while a read is in flight
        drive(1'b1, 1'b0, 5, '0);
        step();
        drive(1'b0, 1'b0, 0, '0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_inflight_ceb", sram_CEB, 1'b1);
        step();
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", req_ready, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
            step();
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) == 0,
                  int'($urandom % 16), $urandom);
            rsp_ready = ($urandom % 3) != 0;
            RST = ($urandom % 120) == 0;
            step();
        end
        RST = 1'b0;
        drive(1'b0, 1'b0, 0, '0);
        rsp_ready = 1'b1;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter Bits, 32, data width of the macro word.
REQ-002 Parameter Word_Depth, 32, number of macro words.
REQ-003 Parameter Add_Width, 5, macro address width; SHALL satisfy 2^Add_Width >= Word_Depth.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  Add_Width  word address.
REQ-010 req_wdata  input  Bits  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer takes read data when high together with rsp_valid.
REQ-013 rsp_rdata  output  Bits  read data, in request order.
REQ-014 sram_CEB  output  1  macro chip enable, active-low.
REQ-015 sram_WEB  output  1  macro write enable, active-low (0 = write, 1 = read).
REQ-016 sram_A  output  Add_Width  macro address.
REQ-017 sram_D  output  Bits  macro write data.
REQ-018 sram_Q  input  Bits  macro registered read data; valid only in the cycle after a read command.

Function
REQ-019 The block SHALL act as the initiator for one single-port macro: each accepted request produces exactly one macro command in the same cycle.
REQ-020 req_fire = req_valid & req_ready; rsp_fire = rsp_valid & rsp_ready.
REQ-021 The block SHALL drive sram_CEB = !req_fire combinationally, with sram_WEB = !req_write, sram_A = req_addr, sram_D = req_wdata.
REQ-022 When sram_CEB = 1, sram_WEB SHALL be 1 and sram_A/sram_D SHALL be don't-care.
REQ-023 Read latency: a read accepted in cycle N SHALL have sram_Q captured at the end of cycle N+1; rsp_valid SHALL be asserted no earlier than cycle N+2.
REQ-024 The block SHALL hold an in-flight flag, set for one cycle after each read command, and SHALL capture sram_Q only while this flag is set; sram_Q SHALL be ignored in all other cycles.
REQ-025 Read data SHALL be stored in a 2-entry FIFO (count 0..2); rsp_rdata SHALL be the head entry; rsp_valid = (count != 0).
REQ-026 Writes produce no response, SHALL NOT enter the FIFO, and SHALL be accepted whenever not in reset (req_ready = 1 for req_write = 1).
REQ-027 For reads, req_ready = (count + inflight - rsp_fire < 2); this is a combinational path from rsp_ready to req_ready.
REQ-028 Simultaneous capture and rsp_fire SHALL leave count unchanged and preserve order; with count = 2, capture SHALL NOT occur (this is guaranteed by REQ-027).
REQ-029 Sustained reads with rsp_ready = 1 SHALL reach one read per cycle.
REQ-030 Requests SHALL be executed in acceptance order. A read following a write to the same address SHALL return the written data, because the macro serializes them.
REQ-031 rsp_rdata SHALL be held stable while rsp_valid = 1 and rsp_ready = 0.
REQ-032 req_* inputs SHALL be ignored while req_ready = 0.

Reset
REQ-033 While RST = 1: req_ready = 0, sram_CEB = 1, sram_WEB = 1, rsp_valid = 0, count = 0, inflight = 0.
REQ-034 A read in flight when RST asserts SHALL be discarded; its sram_Q SHALL NOT be captured after reset.
REQ-035 In the first cycle with RST = 0, req_ready SHALL be 1.

Verification
REQ-036 Write addr 3 = 0xDEADBEEF, then read addr 3, rsp_ready = 1 -> sram_CEB low in both cycles; rsp_valid two cycles after the read; rsp_rdata = 0xDEADBEEF.
REQ-037 Back-to-back reads of addrs 0..7 preloaded with value = addr, rsp_ready = 1 -> req_ready stays 1; rsp_rdata = 0..7 on 8 consecutive cycles.
REQ-038 rsp_ready = 0 with 4 reads offered -> 2 reads accepted; req_ready = 0 for reads while writes are still accepted; rsp_rdata is stable; raising rsp_ready drains in order.
REQ-039 sram_Q driven with random values in idle and write cycles -> FIFO contents and rsp_valid unaffected.
REQ-040 Assert RST one cycle after a read is accepted -> no rsp_valid after reset; sram_CEB = 1 during reset; req_ready = 1 in the first cycle after release.
